// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between the CPU memory interface and a secondary (loader/DMA) port.
// CPU wins by default; a saturating starvation counter forces a DMA slot after STARVE_MAX denials.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cpu_mem_cmd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [2:0] FORCE_CNT = 3'(STARVE_MAX);

  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       dma_rvalid_q, dma_rvalid_d;
  logic       cpu_active;
  logic       dma_sel;

  // State register: wait_cnt is the starvation FSM (COUNT 0..STARVE_MAX-1, FORCE = STARVE_MAX).
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q   <= 3'd0;
      dma_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    dma_rvalid_d = dma_sel & ~dma_we;
    if (!dma_req || dma_sel) begin
      wait_cnt_d = 3'd0;
    end else if (wait_cnt_q < FORCE_CNT) begin
      wait_cnt_d = wait_cnt_q + 3'd1;
    end
  end

  // Output logic: grant decision and RAM port mux.
  always_comb begin
    cpu_active = (cpu_mem_cmd == CMD_READ) || (cpu_mem_cmd == CMD_WRITE);
    dma_sel    = rst & dma_req & (~cpu_active | (wait_cnt_q == FORCE_CNT));
    dma_gnt    = dma_sel;
    cpu_stall  = rst & cpu_active & dma_sel;
    ram_addr   = cpu_addr;
    ram_wdata  = cpu_wdata;
    ram_we     = (cpu_mem_cmd == CMD_WRITE) & rst;
    if (dma_sel) begin
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
      ram_we    = dma_we;
    end
  end

  // Read data is shared; each side qualifies it by its own timing.
  assign cpu_rdata  = ram_rdata;
  assign dma_rdata  = ram_rdata;
  assign dma_rvalid = dma_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural RAM plus a spec-level model of the
// grant rules and memory contents; a negedge monitor compares DUT outputs against queued expectations.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        cpu_mem_cmd;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_mem_cmd(cpu_mem_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Registered-read single-port RAM the arbiter drives.
  logic [DATA_W-1:0] ram_mem [1<<ADDR_W];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  typedef struct {
    logic              gnt;
    logic              stall;
    logic              we;
    logic              rvalid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ctrl_t;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
  } rd_t;

  ctrl_t             ctrl_q [$];
  logic [DATA_W-1:0] dma_q  [$];
  rd_t               cpu_q  [$];

  // Reference model state: denied-streak length, last-cycle DMA read, memory image.
  int                streak;
  bit                prev_dma_read;
  logic [DATA_W-1:0] shadow [1<<ADDR_W];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    ctrl_t e;
    bit    active;
    bit    grant;
    rd_t   r;
    active   = (cpu_mem_cmd == 2'b01) || (cpu_mem_cmd == 2'b10);
    grant    = dma_req && (!active || streak >= STARVE_MAX);
    e.gnt    = grant;
    e.stall  = active && grant;
    e.we     = grant ? dma_we : (cpu_mem_cmd == 2'b10);
    e.addr   = grant ? dma_addr : cpu_addr;
    e.wdata  = grant ? dma_wdata : cpu_wdata;
    e.rvalid = prev_dma_read;
    ctrl_q.push_back(e);
    if (grant && !dma_we) dma_q.push_back(shadow[dma_addr]);
    if (!grant && cpu_mem_cmd == 2'b01) begin
      r.cyc  = cyc + 1;
      r.data = shadow[cpu_addr];
      cpu_q.push_back(r);
    end
    if (grant && dma_we) shadow[dma_addr] = dma_wdata;
    if (!grant && cpu_mem_cmd == 2'b10) shadow[cpu_addr] = cpu_wdata;
    streak        = (!dma_req || grant) ? 0 : streak + 1;
    prev_dma_read = grant && !dma_we;
  endtask

  // Applies one cycle of stimulus just after the rising edge (also releases any pending reset).
  task automatic drive(input logic [1:0] cmd, input logic [ADDR_W-1:0] caddr,
                       input logic [DATA_W-1:0] cwd, input logic req, input logic we,
                       input logic [ADDR_W-1:0] daddr, input logic [DATA_W-1:0] dwd);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    cpu_mem_cmd = cmd;
    cpu_addr    = caddr;
    cpu_wdata   = cwd;
    dma_req     = req;
    dma_we      = we;
    dma_addr    = daddr;
    dma_wdata   = dwd;
    model_step();
    mon_en = 1'b1;
  endtask

  task automatic drive_chk(input string name, input logic [1:0] cmd, input logic [ADDR_W-1:0] caddr,
                           input logic [DATA_W-1:0] cwd, input logic req, input logic we,
                           input logic [ADDR_W-1:0] daddr, input logic exp_gnt, input logic exp_stall,
                           input logic exp_we, input logic [ADDR_W-1:0] exp_addr);
    drive(cmd, caddr, cwd, req, we, daddr, 16'h5A5A);
    #1;
    check({name, ".gnt"},   32'(dma_gnt),   32'(exp_gnt));
    check({name, ".stall"}, 32'(cpu_stall), 32'(exp_stall));
    check({name, ".we"},    32'(ram_we),    32'(exp_we));
    check({name, ".addr"},  32'(ram_addr),  32'(exp_addr));
  endtask

  task automatic idle();
    drive(2'b00, 9'h000, 16'h0000, 1'b0, 1'b0, 9'h000, 16'h0000);
  endtask

  // Pulls reset low between edges; pending expectations for the interrupted cycle are discarded.
  task automatic async_reset_mid_cycle();
    #1;
    rst    = 1'b0;
    mon_en = 1'b0;
    ctrl_q.delete();
    dma_q.delete();
    cpu_q.delete();
    streak        = 0;
    prev_dma_read = 1'b0;
    #1;
  endtask

  // Monitor: per-cycle control expectations, DMA read data on dma_rvalid, CPU read data one cycle on.
  ctrl_t mon_e;
  rd_t   mon_r;
  always @(negedge clk) begin
    if (mon_en) begin
      if (ctrl_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL ctrl_q: no expectation queued (cycle %0d)", cyc);
      end else begin
        mon_e = ctrl_q.pop_front();
        check("mon.dma_gnt",    32'(dma_gnt),    32'(mon_e.gnt));
        check("mon.cpu_stall",  32'(cpu_stall),  32'(mon_e.stall));
        check("mon.ram_we",     32'(ram_we),     32'(mon_e.we));
        check("mon.ram_addr",   32'(ram_addr),   32'(mon_e.addr));
        check("mon.ram_wdata",  32'(ram_wdata),  32'(mon_e.wdata));
        check("mon.dma_rvalid", 32'(dma_rvalid), 32'(mon_e.rvalid));
      end
      if (dma_rvalid) begin
        if (dma_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL dma_rdata: dma_rvalid=1 with no read outstanding (cycle %0d)", cyc);
        end else begin
          check("mon.dma_rdata", 32'(dma_rdata), 32'(dma_q.pop_front()));
        end
      end
      if (cpu_q.size() > 0 && cpu_q[0].cyc == cyc) begin
        mon_r = cpu_q.pop_front();
        check("mon.cpu_rdata", 32'(cpu_rdata), 32'(mon_r.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram_mem[i] = '0;
      shadow[i]  = '0;
    end
    streak        = 0;
    prev_dma_read = 1'b0;

    // Reset held with a CPU write and a DMA write both pending.
    rst = 1'b0; cpu_mem_cmd = 2'b10; cpu_addr = 9'h033; cpu_wdata = 16'hCAFE;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 9'h011; dma_wdata = 16'hDEAD;
    repeat (2) @(posedge clk);
    #2;
    check("rst.dma_gnt",    32'(dma_gnt),    32'd0);
    check("rst.cpu_stall",  32'(cpu_stall),  32'd0);
    check("rst.ram_we",     32'(ram_we),     32'd0);
    check("rst.dma_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst.ram_addr",   32'(ram_addr),   32'h033);
    check("rst.ram_wdata",  32'(ram_wdata),  32'hCAFE);

    // Idle CPU: DMA write then read of address 5.
    drive(2'b00, 9'h000, 16'h0000, 1'b1, 1'b1, 9'h005, 16'h1234);
    #1;
    check("idle_wr.gnt", 32'(dma_gnt), 32'd1);
    drive_chk("idle_rd", 2'b00, 9'h000, 16'h0, 1'b1, 1'b0, 9'h005, 1'b1, 1'b0, 1'b0, 9'h005);
    idle();
    #1;
    check("idle_rd.rvalid", 32'(dma_rvalid), 32'd1);
    check("idle_rd.rdata",  32'(dma_rdata),  32'h1234);

    // CPU write with no contention.
    drive_chk("cpu_wr", 2'b10, 9'h0A0, 16'hBEEF, 1'b0, 1'b0, 9'h005, 1'b0, 1'b0, 1'b1, 9'h0A0);

    // Starvation under continuous CPU reads: grants on cycles 4 and 9.
    idle();
    for (int c = 0; c < 10; c++) begin
      if (c == 4 || c == 9)
        drive_chk($sformatf("starve%0d", c), 2'b01, 9'h0A0, 16'h0, 1'b1, 1'b0, 9'h005,
                  1'b1, 1'b1, 1'b0, 9'h005);
      else
        drive_chk($sformatf("starve%0d", c), 2'b01, 9'h0A0, 16'h0, 1'b1, 1'b0, 9'h005,
                  1'b0, 1'b0, 1'b0, 9'h0A0);
    end

    // Request withdrawn in FORCE: no grant, counter back at 0 so the next grant is cycle 9.
    idle();
    for (int c = 0; c < 10; c++) begin
      if (c == 4)
        drive_chk("withdraw4", 2'b01, 9'h0A0, 16'h0, 1'b0, 1'b0, 9'h005, 1'b0, 1'b0, 1'b0, 9'h0A0);
      else if (c == 9)
        drive_chk("withdraw9", 2'b01, 9'h0A0, 16'h0, 1'b1, 1'b0, 9'h005, 1'b1, 1'b1, 1'b0, 9'h005);
      else
        drive_chk($sformatf("withdraw%0d", c), 2'b01, 9'h0A0, 16'h0, 1'b1, 1'b0, 9'h005,
                  1'b0, 1'b0, 1'b0, 9'h0A0);
    end

    // Reserved command counts as no CPU access.
    idle();
    drive_chk("rsvd", 2'b11, 9'h0A0, 16'hFFFF, 1'b1, 1'b0, 9'h005, 1'b1, 1'b0, 1'b0, 9'h005);

    // Async reset with wait_cnt=3: after release the grant needs four fresh denials.
    idle();
    for (int c = 0; c < 4; c++)
      drive_chk($sformatf("arst_pre%0d", c), 2'b01, 9'h0A0, 16'h0, 1'b1, 1'b0, 9'h005,
                1'b0, 1'b0, 1'b0, 9'h0A0);
    async_reset_mid_cycle();
    check("arst.dma_gnt",   32'(dma_gnt),   32'd0);
    check("arst.cpu_stall", 32'(cpu_stall), 32'd0);
    check("arst.ram_addr",  32'(ram_addr),  32'h0A0);
    for (int c = 0; c < 5; c++)
      drive_chk($sformatf("arst_post%0d", c), 2'b01, 9'h0A0, 16'h0, 1'b1, 1'b0, 9'h005,
                c == 4, c == 4, 1'b0, (c == 4) ? 9'h005 : 9'h0A0);

    // Async reset clears dma_rvalid without a clock edge.
    idle();
    drive_chk("rv_rd", 2'b00, 9'h000, 16'h0, 1'b1, 1'b0, 9'h005, 1'b1, 1'b0, 1'b0, 9'h005);
    idle();
    #1;
    check("rv.before", 32'(dma_rvalid), 32'd1);
    async_reset_mid_cycle();
    check("rv.after_rst", 32'(dma_rvalid), 32'd0);

    // Randomized traffic over a small address window for frequent read-after-write hits.
    for (int i = 0; i < 300; i++)
      drive(2'($urandom_range(0, 3)), 9'($urandom_range(0, 15)), 16'($urandom),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            9'($urandom_range(0, 15)), 16'($urandom));

    idle();
    idle();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("drain.dma_q", 32'(dma_q.size()), 32'd0);
    check("drain.cpu_q", 32'(cpu_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port data/instruction RAM between the CPU's memory interface (driven by the CPU state machine's `mem_cmd`/address path) and a secondary requester port (program loader / DMA). The CPU has priority by default. A saturating starvation counter guarantees the secondary port a slot after a bounded wait; the CPU is stalled for that slot. The block sits between the CPU top level and the RAM instance.

## Interface
Parameters:
- `ADDR_W`, 9: RAM word-address width.
- `DATA_W`, 16: RAM data width.
- `STARVE_MAX`, 4: consecutive denied DMA cycles before a forced DMA grant. Legal range 1..7.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_mem_cmd` in 2: 00 none, 01 read, 10 write, 11 reserved (treated as none).
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_rdata` out DATA_W: RAM read data returned to the CPU.
- `cpu_stall` out 1: CPU access not performed this cycle; the CPU holds its command.
- `dma_req` in 1: secondary port requests an access this cycle.
- `dma_we` in 1: 1 = write, 0 = read (valid with `dma_req`).
- `dma_addr` in ADDR_W, `dma_wdata` in DATA_W: secondary address and write data.
- `dma_gnt` out 1: secondary access performed this cycle.
- `dma_rdata` out DATA_W: RAM read data returned to the secondary port.
- `dma_rvalid` out 1: `dma_rdata` is valid (read granted the previous cycle).
- `ram_addr` out ADDR_W, `ram_we` out 1, `ram_wdata` out DATA_W: RAM port.
- `ram_rdata` in DATA_W: RAM read data, one-cycle registered-read latency.

## Operation
- `cpu_active` is `cpu_mem_cmd` ∈ {01, 10}.
- Grant decision is combinational, once per cycle.
  - `dma_sel` = `rst` & `dma_req` & (!`cpu_active` | `wait_cnt` == STARVE_MAX).
  - `dma_gnt` = `dma_sel`.
  - `cpu_stall` = `rst` & `cpu_active` & `dma_sel`.
- RAM mux:
  - `dma_sel` = 1: `ram_addr`=`dma_addr`, `ram_wdata`=`dma_wdata`, `ram_we`=`dma_we`.
  - `dma_sel` = 0: `ram_addr`=`cpu_addr`, `ram_wdata`=`cpu_wdata`, `ram_we`=(`cpu_mem_cmd`==10) & `rst`.
- `cpu_rdata` = `dma_rdata` = `ram_rdata` (passthrough). Consumers qualify the data by their own timing; `dma_rvalid` qualifies the secondary side.
- `wait_cnt` (3-bit, registered) is the starvation state machine. States are COUNT(0..STARVE_MAX−1) and FORCE(STARVE_MAX).
  - `dma_req`=0: go to 0.
  - `dma_req`=1 & granted: go to 0.
  - `dma_req`=1 & denied: increment, saturating at STARVE_MAX.
  - In FORCE with `dma_req`=1, the grant is guaranteed, so FORCE always returns to 0 or exits via a `dma_req` drop.
- `dma_rvalid` register is set to `dma_sel` & !`dma_we` on each edge.

## Timing
- Reset (`rst`=0, asynchronous): `wait_cnt`=0, `dma_rvalid`=0 immediately.
  - Combinational outputs are forced: `dma_gnt`=0, `cpu_stall`=0, `ram_we`=0.
  - Passthrough outputs continue to follow their inputs: `ram_addr`=`cpu_addr`, `ram_wdata`=`cpu_wdata`, `cpu_rdata`/`dma_rdata`=`ram_rdata`.
- Reset released mid-request: the first granted cycle follows the normal rule from `wait_cnt`=0.
- Read latency: address presented in cycle N, data on `ram_rdata` and `dma_rvalid`=1 in cycle N+1.
- Write: RAM captures at the end of the granted cycle.
- Worst-case DMA wait under continuous CPU traffic: STARVE_MAX denied cycles, then a grant on cycle STARVE_MAX+1.
- Worst-case CPU stall: 1 cycle per STARVE_MAX+1 cycles of contention. After a forced grant the counter restarts at 0.
- `dma_req` falls while in FORCE: no grant, no stall, counter goes to 0.
- `cpu_mem_cmd`=11 with `dma_req`: DMA granted immediately, `cpu_stall`=0.
- No other cross-port ordering is enforced. A CPU read and a DMA write to the same address in adjacent cycles see RAM-native ordering.

## Test plan
- Reset: hold `rst`=0 with `dma_req`=1, `cpu_mem_cmd`=10 → `dma_gnt`=0, `cpu_stall`=0, `ram_we`=0, `dma_rvalid`=0.
- Idle CPU: `cpu_mem_cmd`=00, DMA write 0x1234 to addr 5, then DMA read addr 5 → `dma_gnt`=1 both cycles, `dma_rvalid`=1 one cycle after the read, `dma_rdata`=0x1234.
- Starvation, STARVE_MAX=4: `cpu_mem_cmd`=01 continuous, `dma_req`=1 from cycle 0 → `dma_gnt`=0 on cycles 0–3. Cycle 4: `dma_gnt`=1, `cpu_stall`=1, `ram_addr`=`dma_addr`. Cycle 5: `dma_gnt`=0 and counter restarts, next grant on cycle 9.
- Request withdrawal: as above, drop `dma_req` on cycle 4 → `cpu_stall`=0, CPU access proceeds, `wait_cnt`=0 on cycle 5.
- Reserved command: `cpu_mem_cmd`=11, DMA read → immediate grant, `cpu_stall`=0, `ram_we`=0.
- Async reset mid-run: assert `rst`=0 between edges with `wait_cnt`=3 and `dma_rvalid`=1 → both clear without a clock edge. After release, the grant sequence restarts from count 0.
